// File: rtl/pri_rr_arb_pkg.sv
// pri_pkg: shared types and constants for the pri_rr_arb arbiter.
//   mode_t        - arbitration mode (fixed priority / round-robin)
//   DEFAULT_WIDTH - default request vector width
//   wrap_inc      - modulo increment used for the round-robin pointer
package pri_pkg;

    typedef enum logic {
        PRI_FIXED = 1'b0,
        PRI_RR    = 1'b1
    } mode_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // (v + 1) mod width, correct for any width, not only powers of two.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned width);
        if (v + 1 >= width) begin
            return 0;
        end
        return v + 1;
    endfunction

endpackage

// File: rtl/pri_rr_arb_if.sv
// pri_rr_arb_if: request/grant handshake bundle for pri_rr_arb.
//   mode_i        - arbitration mode, sampled with each accepted request
//   req_valid_i   - request vector valid
//   req_ready_o   - arbiter can accept a request this cycle
//   req_i         - request bits, bit k = requester k
//   grant_valid_o - result valid
//   grant_ready_i - downstream accepts the result
//   grant_o       - one-hot grant (zero when nothing requested)
//   idx_o         - binary index of granted bit
//   none_o        - accepted request vector was all-zero
// Modport slave is the arbiter side, master is the requester/consumer side.
interface pri_rr_arb_if #(
    parameter int unsigned WIDTH = pri_pkg::DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
);
    import pri_pkg::*;

    mode_t              mode_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [WIDTH-1:0]   req_i;
    logic               grant_valid_o;
    logic               grant_ready_i;
    logic [WIDTH-1:0]   grant_o;
    logic [IDX_W-1:0]   idx_o;
    logic               none_o;

    modport slave (
        input  mode_i,
        input  req_valid_i,
        input  req_i,
        input  grant_ready_i,
        output req_ready_o,
        output grant_valid_o,
        output grant_o,
        output idx_o,
        output none_o
    );

    modport master (
        output mode_i,
        output req_valid_i,
        output req_i,
        output grant_ready_i,
        input  req_ready_o,
        input  grant_valid_o,
        input  grant_o,
        input  idx_o,
        input  none_o
    );

endinterface

// File: rtl/pri_rr_arb_rot_nb.sv
// pri_rot_nb: combinational find-first-set starting at a given index.
// Scans ascending indices from start, wrapping from WIDTH-1 to 0.
//   req    - request vector
//   start  - first index to examine (must be < WIDTH)
//   onehot - one-hot winner, zero when no bit is set
//   idx    - binary index of winner, zero when no bit is set
//   none   - no bit of req is set
module pri_rot_nb #(
    parameter int unsigned WIDTH = pri_pkg::DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    int unsigned pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        none   = 1'b1;
        pos    = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = 32'(start) + i;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            // 'none' doubles as the "not found yet" flag so only the first hit wins.
            if (none && req[pos[IDX_W-1:0]]) begin
                onehot[pos[IDX_W-1:0]] = 1'b1;
                idx                    = pos[IDX_W-1:0];
                none                   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pri_rr_arb.sv
// pri_rr_arb: fixed-priority / round-robin arbiter with valid/ready
// handshakes on both sides and a one-cycle registered result.
//   clk_i - clock, all state updates on rising edge
//   rst_i - asynchronous active-high reset
//   bus   - pri_rr_arb_if slave modport (request in, grant out)
module pri_rr_arb #(
    parameter int unsigned WIDTH = pri_pkg::DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pri_rr_arb_if.slave     bus
);
    import pri_pkg::*;

    logic [IDX_W-1:0] ptr_q;
    logic             grant_valid_q;
    logic [WIDTH-1:0] grant_q;
    logic [IDX_W-1:0] idx_q;
    logic             none_q;

    logic             ready;
    logic             accept;

    logic [WIDTH-1:0] fix_onehot;
    logic [IDX_W-1:0] fix_idx;
    logic             fix_none;
    logic [WIDTH-1:0] rr_onehot;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_none;

    logic [WIDTH-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_none;
    logic             sel_rr;
    logic [IDX_W-1:0] ptr_next;

    // Fixed priority is just a scan starting at index 0.
    pri_rot_nb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_fix (
        .req    (bus.req_i),
        .start  ('0),
        .onehot (fix_onehot),
        .idx    (fix_idx),
        .none   (fix_none)
    );

    pri_rot_nb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (bus.req_i),
        .start  (ptr_q),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .none   (rr_none)
    );

    always_comb begin
        ready      = !grant_valid_q || bus.grant_ready_i;
        accept     = bus.req_valid_i && ready;
        sel_rr     = (bus.mode_i == PRI_RR);
        sel_onehot = sel_rr ? rr_onehot : fix_onehot;
        sel_idx    = sel_rr ? rr_idx    : fix_idx;
        sel_none   = sel_rr ? rr_none   : fix_none;
        ptr_next   = IDX_W'(wrap_inc(32'(rr_idx), WIDTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            idx_q         <= '0;
            none_q        <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh load and a back-to-back transfer+load.
            grant_valid_q <= 1'b1;
            grant_q       <= sel_onehot;
            idx_q         <= sel_idx;
            none_q        <= sel_none;
            if (sel_rr && !rr_none) begin
                ptr_q <= ptr_next;
            end
        end else if (bus.grant_ready_i) begin
            grant_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready_o   = ready;
    assign bus.grant_valid_o = grant_valid_q;
    assign bus.grant_o       = grant_q;
    assign bus.idx_o         = idx_q;
    assign bus.none_o        = none_q;

endmodule

// File: tb/tb_pri_rr_arb.sv
// tb_pri_rr_arb: self-checking bench for pri_rr_arb (WIDTH = 8).
// Table of back-to-back accepts with expected results, plus hand-written
// sequences for backpressure and asynchronous reset.
module tb_pri_rr_arb;
    import pri_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    logic clk;
    logic rst;

    pri_rr_arb_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    pri_rr_arb #(
        .WIDTH (W),
        .IDX_W (IW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit              do_rst;
        mode_t           mode;
        logic [W-1:0]    req;
        logic [W-1:0]    grant;
        logic [IW-1:0]   idx;
        logic            none;
        logic [IW-1:0]   ptr;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check the reset state while it is held, release just after an edge.
    task automatic do_reset();
        rst               = 1'b1;
        bus.req_valid_i   = 1'b0;
        bus.req_i         = '0;
        bus.grant_ready_i = 1'b1;
        bus.mode_i        = PRI_FIXED;
        #1;
        check("rst_grant_valid", 32'(bus.grant_valid_o), 32'd0);
        check("rst_grant",       32'(bus.grant_o),       32'd0);
        check("rst_idx",         32'(bus.idx_o),         32'd0);
        check("rst_none",        32'(bus.none_o),        32'd0);
        check("rst_ptr",         32'(dut.ptr_q),         32'd0);
        check("rst_req_ready",   32'(bus.req_ready_o),   32'd1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.mode_i        = PRI_FIXED;
        bus.req_valid_i   = 1'b0;
        bus.req_i         = '0;
        bus.grant_ready_i = 1'b1;

        // Fixed priority: lowest set bit, ptr untouched.
        vecs[0] = '{1'b1, PRI_FIXED, 8'h7a, 8'h02, 3'd1, 1'b0, 3'd0};
        vecs[1] = '{1'b0, PRI_FIXED, 8'h4f, 8'h01, 3'd0, 1'b0, 3'd0};
        vecs[2] = '{1'b0, PRI_FIXED, 8'hcd, 8'h01, 3'd0, 1'b0, 3'd0};
        // Round-robin over a full vector: walks every bit, wraps to bit 0.
        for (int i = 0; i < 9; i++) begin
            vecs[3+i] = '{(i == 0), PRI_RR, 8'hff, 8'(1 << (i % 8)), 3'(i % 8), 1'b0,
                          3'((i + 1) % 8)};
        end
        // Round-robin on a sparse vector, including wrap past WIDTH-1.
        vecs[12] = '{1'b1, PRI_RR, 8'h0a, 8'h02, 3'd1, 1'b0, 3'd2};
        vecs[13] = '{1'b0, PRI_RR, 8'h0a, 8'h08, 3'd3, 1'b0, 3'd4};
        vecs[14] = '{1'b0, PRI_RR, 8'h0a, 8'h02, 3'd1, 1'b0, 3'd2};
        // All-zero request, then top bit from ptr 0 wraps ptr back to 0.
        vecs[15] = '{1'b1, PRI_RR, 8'h00, 8'h00, 3'd0, 1'b1, 3'd0};
        vecs[16] = '{1'b0, PRI_RR, 8'h80, 8'h80, 3'd7, 1'b0, 3'd0};
        // Non-zero ptr survives an all-zero request and a fixed-mode accept.
        vecs[17] = '{1'b1, PRI_RR,    8'h01, 8'h01, 3'd0, 1'b0, 3'd1};
        vecs[18] = '{1'b0, PRI_RR,    8'h00, 8'h00, 3'd0, 1'b1, 3'd1};
        vecs[19] = '{1'b0, PRI_FIXED, 8'h05, 8'h01, 3'd0, 1'b0, 3'd1};
        vecs[20] = '{1'b0, PRI_RR,    8'h03, 8'h02, 3'd1, 1'b0, 3'd2};

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].do_rst) begin
                do_reset();
            end
            bus.mode_i        = vecs[v].mode;
            bus.req_i         = vecs[v].req;
            bus.req_valid_i   = 1'b1;
            bus.grant_ready_i = 1'b1;
            step();
            check($sformatf("v%0d_valid", v), 32'(bus.grant_valid_o), 32'd1);
            check($sformatf("v%0d_grant", v), 32'(bus.grant_o),       32'(vecs[v].grant));
            check($sformatf("v%0d_idx", v),   32'(bus.idx_o),         32'(vecs[v].idx));
            check($sformatf("v%0d_none", v),  32'(bus.none_o),        32'(vecs[v].none));
            check($sformatf("v%0d_ptr", v),   32'(dut.ptr_q),         32'(vecs[v].ptr));
        end

        // Backpressure: grant 04 held while a queued request waits; a mode
        // change during the hold must not disturb the held result.
        do_reset();
        bus.mode_i        = PRI_FIXED;
        bus.req_i         = 8'h04;
        bus.req_valid_i   = 1'b1;
        bus.grant_ready_i = 1'b0;
        step();
        check("bp_first_grant", 32'(bus.grant_o), 32'h04);
        bus.req_i  = 8'h10;
        bus.mode_i = PRI_RR;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_hold%0d_grant", c), 32'(bus.grant_o),       32'h04);
            check($sformatf("bp_hold%0d_idx", c),   32'(bus.idx_o),         32'd2);
            check($sformatf("bp_hold%0d_valid", c), 32'(bus.grant_valid_o), 32'd1);
            check($sformatf("bp_hold%0d_ready", c), 32'(bus.req_ready_o),   32'd0);
        end
        bus.grant_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready_o), 32'd1);
        step();
        check("bp_next_grant", 32'(bus.grant_o),       32'h10);
        check("bp_next_idx",   32'(bus.idx_o),         32'd4);
        check("bp_next_valid", 32'(bus.grant_valid_o), 32'd1);
        check("bp_next_ptr",   32'(dut.ptr_q),         32'd5);
        // Held with no transfer and no acceptance keeps valid.
        bus.req_valid_i   = 1'b0;
        bus.grant_ready_i = 1'b0;
        step();
        check("idle_hold_valid", 32'(bus.grant_valid_o), 32'd1);
        // Transfer without acceptance drops valid.
        bus.grant_ready_i = 1'b1;
        step();
        check("drain_valid", 32'(bus.grant_valid_o), 32'd0);

        // Asynchronous reset between edges discards the held result at once.
        do_reset();
        bus.mode_i        = PRI_RR;
        bus.req_i         = 8'hff;
        bus.req_valid_i   = 1'b1;
        bus.grant_ready_i = 1'b0;
        step();
        bus.req_valid_i = 1'b0;
        check("ar_pre_valid", 32'(bus.grant_valid_o), 32'd1);
        check("ar_pre_ptr",   32'(dut.ptr_q),         32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(bus.grant_valid_o), 32'd0);
        check("ar_ptr",   32'(dut.ptr_q),         32'd0);
        check("ar_grant", 32'(bus.grant_o),       32'd0);
        check("ar_ready", 32'(bus.req_ready_o),   32'd1);
        step();
        rst               = 1'b0;
        bus.mode_i        = PRI_RR;
        bus.req_i         = 8'hff;
        bus.req_valid_i   = 1'b1;
        bus.grant_ready_i = 1'b1;
        step();
        check("ar_after_valid", 32'(bus.grant_valid_o), 32'd1);
        check("ar_after_grant", 32'(bus.grant_o),       32'h01);
        check("ar_after_ptr",   32'(dut.ptr_q),         32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
